// File: rtl/lemming_array_fsm.sv
// NUM_LEM independent lemming FSMs (walk/dig/fall/splat) with a shared alive count.
// Optional respawn input from SPLAT is enabled by defining LEMMING_RESPAWN_EN.
module lemming_array_fsm #(
    parameter int NUM_LEM     = 4,
    parameter int SPLAT_LIMIT = 20
) (
    input  logic                         clk,
    input  logic                         areset_n,
    input  logic [NUM_LEM-1:0]           bump_left,
    input  logic [NUM_LEM-1:0]           bump_right,
    input  logic [NUM_LEM-1:0]           ground,
    input  logic [NUM_LEM-1:0]           dig,
`ifdef LEMMING_RESPAWN_EN
    input  logic [NUM_LEM-1:0]           respawn,
`endif
    output logic [NUM_LEM-1:0]           walk_left,
    output logic [NUM_LEM-1:0]           walk_right,
    output logic [NUM_LEM-1:0]           aaah,
    output logic [NUM_LEM-1:0]           digging,
    output logic [NUM_LEM-1:0]           splat,
    output logic [$clog2(NUM_LEM+1)-1:0] alive_cnt
);
    localparam int CW = $clog2(SPLAT_LIMIT + 2);
    localparam int AW = $clog2(NUM_LEM + 1);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(SPLAT_LIMIT);
    localparam logic [CW-1:0] CNT_MAX   = CW'(SPLAT_LIMIT + 1);

    typedef enum logic [2:0] {
        S_WL    = 3'd0,
        S_WR    = 3'd1,
        S_FL    = 3'd2,
        S_FR    = 3'd3,
        S_DL    = 3'd4,
        S_DR    = 3'd5,
        S_SPLAT = 3'd6
    } state_t;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LEM; gi++) begin : g_lem
            state_t        state_reg, state_next;
            logic [CW-1:0] fall_cnt_reg, fall_cnt_next;
            logic          wl_reg, wr_reg, aaah_reg, dig_reg, splat_reg;
            logic          respawn_req;

`ifdef LEMMING_RESPAWN_EN
            assign respawn_req = respawn[gi];
`else
            assign respawn_req = 1'b0;
`endif

            always_comb begin
                state_next = state_reg;
                case (state_reg)
                    S_WL: begin
                        if (!ground[gi])        state_next = S_FL;
                        else if (dig[gi])       state_next = S_DL;
                        else if (bump_left[gi]) state_next = S_WR;
                    end
                    S_WR: begin
                        if (!ground[gi])         state_next = S_FR;
                        else if (dig[gi])        state_next = S_DR;
                        else if (bump_right[gi]) state_next = S_WL;
                    end
                    S_DL: if (!ground[gi]) state_next = S_FL;
                    S_DR: if (!ground[gi]) state_next = S_FR;
                    S_FL: if (ground[gi]) state_next = (fall_cnt_reg > CNT_LIMIT) ? S_SPLAT : S_WL;
                    S_FR: if (ground[gi]) state_next = (fall_cnt_reg > CNT_LIMIT) ? S_SPLAT : S_WR;
                    S_SPLAT: if (respawn_req) state_next = S_WL;
                    default: state_next = S_WL;
                endcase

                // Counter tracks the fall the lemming is in next cycle, so it reads 1 on the first aaah cycle.
                fall_cnt_next = '0;
                if (state_next == S_FL || state_next == S_FR)
                    fall_cnt_next = (fall_cnt_reg == CNT_MAX) ? CNT_MAX : fall_cnt_reg + CW'(1);
            end

            always_ff @(posedge clk or negedge areset_n) begin
                if (!areset_n) begin
                    state_reg    <= S_WL;
                    fall_cnt_reg <= '0;
                    wl_reg       <= 1'b1;
                    wr_reg       <= 1'b0;
                    aaah_reg     <= 1'b0;
                    dig_reg      <= 1'b0;
                    splat_reg    <= 1'b0;
                end else begin
                    state_reg    <= state_next;
                    fall_cnt_reg <= fall_cnt_next;
                    wl_reg       <= (state_next == S_WL);
                    wr_reg       <= (state_next == S_WR);
                    aaah_reg     <= (state_next == S_FL) || (state_next == S_FR);
                    dig_reg      <= (state_next == S_DL) || (state_next == S_DR);
                    splat_reg    <= (state_next == S_SPLAT);
                end
            end

            assign walk_left[gi]  = wl_reg;
            assign walk_right[gi] = wr_reg;
            assign aaah[gi]       = aaah_reg;
            assign digging[gi]    = dig_reg;
            assign splat[gi]      = splat_reg;
        end
    endgenerate

    always_comb begin
        alive_cnt = '0;
        for (int i = 0; i < NUM_LEM; i++)
            if (!splat[i]) alive_cnt = alive_cnt + AW'(1);
    end
endmodule
